ycbcr_pixel_sequencer: RTL

//  Unpacks 4:2:2 YCbCr words (two pixels sharing Cb/Cr) and time-shares one external

---
 rtl/ycbcr_pixel_sequencer.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/ycbcr_pixel_sequencer.sv
// ycbcr_pixel_sequencer
//
// Purpose:
//   Unpacks 4:2:2 YCbCr words, where two pixels share one Cb/Cr pair. A single
//   external combinational ycbcr2rgb converter is time-shared between the two
//   pixels of each word. One RGB pixel leaves per output handshake, tagged with
//   its raster x/y position, a start-of-frame flag and an end-of-line flag.
//   The block sits between the frame-buffer read path and the VGA write path.
//
// Parameters:
//   H_ACTIVE  pixels per line; must be even because each input word holds two pixels
//   V_ACTIVE  lines per frame
//
// Ports:
//   clock         system clock
//   reset         synchronous, active-high
//   in_data_i     {Y0[31:24], Cb[23:16], Y1[15:8], Cr[7:0]}
//   in_valid_i    in_data_i is valid
//   in_ready_o    the sequencer accepts in_data_i this cycle
//   conv_y_o      registered Y driven to the converter
//   conv_cb_o     registered Cb driven to the converter
//   conv_cr_o     registered Cr driven to the converter
//   conv_r_i      converter result, red
//   conv_g_i      converter result, green
//   conv_b_i      converter result, blue
//   out_rgb_o     registered {r,g,b} pixel
//   out_valid_o   out_rgb_o is valid
//   out_ready_i   downstream accepts the pixel
//   out_x_o       column of out_rgb_o
//   out_y_o       line of out_rgb_o
//   out_sof_o     first pixel of the frame (qualified by out_valid_o)
//   out_eol_o     last pixel of the line (qualified by out_valid_o)
//   frame_done_o  one-cycle pulse after the last pixel of a frame is handshaken

module ycbcr_pixel_sequencer #(
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned V_ACTIVE = 480
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] in_data_i,
   input  logic        in_valid_i,
   output logic        in_ready_o,
   output logic [7:0]  conv_y_o,
   output logic [7:0]  conv_cb_o,
   output logic [7:0]  conv_cr_o,
   input  logic [7:0]  conv_r_i,
   input  logic [7:0]  conv_g_i,
   input  logic [7:0]  conv_b_i,
   output logic [23:0] out_rgb_o,
   output logic        out_valid_o,
   input  logic        out_ready_i,
   output logic [9:0]  out_x_o,
   output logic [9:0]  out_y_o,
   output logic        out_sof_o,
   output logic        out_eol_o,
   output logic        frame_done_o
);

   localparam logic [9:0] XLast = 10'(H_ACTIVE - 1);
   localparam logic [9:0] YLast = 10'(V_ACTIVE - 1);

   typedef enum logic [1:0] {
      StIdle,
      StConv0,
      StSend0,
      StSend1
   } state_e;

   state_e      state_q, state_d;
   logic [7:0]  y1_q, y1_d;
   logic [7:0]  conv_y_q, conv_y_d;
   logic [7:0]  conv_cb_q, conv_cb_d;
   logic [7:0]  conv_cr_q, conv_cr_d;
   logic [23:0] rgb_q, rgb_d;
   logic        valid_q, valid_d;
   logic [9:0]  x_q, x_d;
   logic [9:0]  y_q, y_d;
   logic        frame_done_q, frame_done_d;

   logic        in_ready;
   logic        in_hs;
   logic        out_hs;

   // Ready is forced low while reset is held so no word is taken mid-reset.
   always_comb begin
      in_ready = 1'b0;
      if (!reset) begin
         unique case (state_q)
            StIdle:  in_ready = 1'b1;
            StSend1: in_ready = out_ready_i;
            default: in_ready = 1'b0;
         endcase
      end
   end

   assign in_hs  = in_valid_i && in_ready;
   assign out_hs = valid_q && out_ready_i;

   // Next-state and datapath.
   always_comb begin
      state_d      = state_q;
      y1_d         = y1_q;
      conv_y_d     = conv_y_q;
      conv_cb_d    = conv_cb_q;
      conv_cr_d    = conv_cr_q;
      rgb_d        = rgb_q;
      valid_d      = valid_q;
      x_d          = x_q;
      y_d          = y_q;
      frame_done_d = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (in_hs) begin
               y1_d      = in_data_i[15:8];
               conv_y_d  = in_data_i[31:24];
               conv_cb_d = in_data_i[23:16];
               conv_cr_d = in_data_i[7:0];
               state_d   = StConv0;
            end
         end
         StConv0: begin
            // Converter has had a full cycle on pixel 0; capture it and
            // swap in Y1 so pixel 1 settles while pixel 0 waits downstream.
            rgb_d    = {conv_r_i, conv_g_i, conv_b_i};
            valid_d  = 1'b1;
            conv_y_d = y1_q;
            state_d  = StSend0;
         end
         StSend0: begin
            if (out_hs) begin
               rgb_d   = {conv_r_i, conv_g_i, conv_b_i};
               state_d = StSend1;
            end
         end
         StSend1: begin
            if (out_hs) begin
               valid_d = 1'b0;
               // in_hs can only occur here together with out_hs.
               if (in_hs) begin
                  y1_d      = in_data_i[15:8];
                  conv_y_d  = in_data_i[31:24];
                  conv_cb_d = in_data_i[23:16];
                  conv_cr_d = in_data_i[7:0];
                  state_d   = StConv0;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         default: begin
            state_d = StIdle;
            valid_d = 1'b0;
         end
      endcase

      // Raster position follows the output handshake.
      if (out_hs) begin
         if (x_q == XLast) begin
            x_d = '0;
            if (y_q == YLast) begin
               y_d          = '0;
               frame_done_d = 1'b1;
            end else begin
               y_d = y_q + 10'd1;
            end
         end else begin
            x_d = x_q + 10'd1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= StIdle;
         y1_q         <= '0;
         conv_y_q     <= '0;
         conv_cb_q    <= '0;
         conv_cr_q    <= '0;
         rgb_q        <= '0;
         valid_q      <= 1'b0;
         x_q          <= '0;
         y_q          <= '0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         y1_q         <= y1_d;
         conv_y_q     <= conv_y_d;
         conv_cb_q    <= conv_cb_d;
         conv_cr_q    <= conv_cr_d;
         rgb_q        <= rgb_d;
         valid_q      <= valid_d;
         x_q          <= x_d;
         y_q          <= y_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign in_ready_o   = in_ready;
   assign conv_y_o     = conv_y_q;
   assign conv_cb_o    = conv_cb_q;
   assign conv_cr_o    = conv_cr_q;
   assign out_rgb_o    = rgb_q;
   assign out_valid_o  = valid_q;
   assign out_x_o      = x_q;
   assign out_y_o      = y_q;
   // Flags are qualified by valid so they read 0 out of reset.
   assign out_sof_o    = valid_q && (x_q == '0) && (y_q == '0);
   assign out_eol_o    = valid_q && (x_q == XLast);
   assign frame_done_o = frame_done_q;

endmodule
